// File: rtl/bus_arbiter_rr.sv
// Shared-bus arbiter: registered one-hot grant, split re-grant, ack timeout, protocol-error pulse.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the highest-index request wins.
module bus_arbiter_rr #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 3,
   parameter int ACK_TIMEOUT = 8,
   localparam int ID_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_MASTERS-1:0]           req,
   input  logic [NUM_SLAVES*NUM_MASTERS-1:0] split_req,
   input  logic [NUM_MASTERS-1:0]           util,
   output logic [NUM_MASTERS-1:0]           grant,
   output logic [NUM_SLAVES*NUM_MASTERS-1:0] gmaster,
   output logic [ID_W-1:0]                  owner_id,
   output logic                             timeout,
   output logic                             proto_err
);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [NUM_MASTERS-1:0] eff, winner_vec;
   logic [ID_W-1:0]        owner_q, owner_d, winner;
   logic [7:0]             ack_q, ack_d;
   logic                   timeout_q, timeout_d;
   logic                   proto_err_q, proto_err_d;
   logic                   util_own, eff_own, new_grant;

   // A slave's split request stands in for the master's own bus request.
   always_comb begin
      eff = req;
      for (int s = 0; s < NUM_SLAVES; s++)
         eff = eff | split_req[s*NUM_MASTERS +: NUM_MASTERS];
   end

   assign util_own = |(util & grant_q);
   assign eff_own  = |(eff & grant_q);

`ifdef ROUND_ROBIN_EN
   logic [ID_W-1:0] last_q, last_d;
   logic            rr_found;

   // Search downward from last_owner-1 with wrap, so the previous owner is considered last.
   always_comb begin
      winner   = '0;
      rr_found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!rr_found && eff[(int'(last_q) + NUM_MASTERS - k) % NUM_MASTERS]) begin
            winner   = ID_W'((int'(last_q) + NUM_MASTERS - k) % NUM_MASTERS);
            rr_found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      winner = '0;
      for (int m = 0; m < NUM_MASTERS; m++)
         if (eff[m]) winner = ID_W'(m);
   end
`endif

   always_comb begin
      winner_vec         = '0;
      winner_vec[winner] = 1'b1;
   end

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      ack_d       = ack_q;
      timeout_d   = 1'b0;
      proto_err_d = |(util & ~grant_q);
      new_grant   = 1'b0;
`ifdef ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|eff) new_grant = 1'b1;
         end
         GRANT: begin
            // util is tested first so it beats a timeout expiring in the same cycle.
            if (util_own) begin
               state_d = BUSY;
            end else if (!eff_own) begin
               state_d = IDLE;
               grant_d = '0;
               owner_d = '0;
            end else if (ack_q == 8'(ACK_TIMEOUT - 1)) begin
               state_d   = IDLE;
               grant_d   = '0;
               owner_d   = '0;
               ack_d     = '0;
               timeout_d = 1'b1;
            end else begin
               ack_d = ack_q + 8'd1;
            end
         end
         BUSY: begin
            if (!util_own) begin
               if (|eff) begin
                  new_grant = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  owner_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
         end
      endcase

      if (new_grant) begin
         state_d = GRANT;
         grant_d = winner_vec;
         owner_d = winner;
         ack_d   = '0;
`ifdef ROUND_ROBIN_EN
         last_d  = winner;
`endif
      end
   end

   // NOTE: non-blocking assignments make every register update from the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         owner_q     <= '0;
         ack_q       <= '0;
         timeout_q   <= 1'b0;
         proto_err_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
         last_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         owner_q     <= owner_d;
         ack_q       <= ack_d;
         timeout_q   <= timeout_d;
         proto_err_q <= proto_err_d;
`ifdef ROUND_ROBIN_EN
         last_q      <= last_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign gmaster   = {NUM_SLAVES{grant_q}};
   assign owner_id  = owner_q;
   assign timeout   = timeout_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed literal checks plus randomized traffic against a per-cycle
// behavioural model of who owns the bus. Honours ROUND_ROBIN_EN like the design.
module tb_bus_arbiter_rr;
   localparam int N   = 2;
   localparam int S   = 3;
   localparam int T   = 8;
   localparam int IDW = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req, util, grant;
   logic [S*N-1:0]   split_req, gmaster;
   logic [IDW-1:0]   owner_id;
   logic             timeout, proto_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_arbiter_rr #(.NUM_MASTERS(N), .NUM_SLAVES(S), .ACK_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .req(req), .split_req(split_req), .util(util),
      .grant(grant), .gmaster(gmaster), .owner_id(owner_id),
      .timeout(timeout), .proto_err(proto_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: owner index (-1 = none), whether the owner has started using the bus,
   // and how many cycles the owner has waited since being granted.
   int           m_own  = -1;
   bit           m_busy = 1'b0;
   int           m_age  = 0;
   bit           m_tmo  = 1'b0;
   bit           m_perr = 1'b0;
   logic [N-1:0] m_eff;
`ifdef ROUND_ROBIN_EN
   int           m_last = 0;
`endif

   function automatic int pick(input logic [N-1:0] e);
`ifdef ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++)
         if (e[(m_last - k + N) % N]) return (m_last - k + N) % N;
`else
      for (int c = N - 1; c >= 0; c--)
         if (e[c]) return c;
`endif
      return -1;
   endfunction

   function automatic logic [N-1:0] own_vec(input int o);
      logic [N-1:0] v;
      v = '0;
      if (o >= 0) v[o] = 1'b1;
      return v;
   endfunction

   task automatic model_grant();
      m_own  = pick(m_eff);
      m_busy = 1'b0;
      m_age  = 0;
`ifdef ROUND_ROBIN_EN
      m_last = m_own;
`endif
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_own = -1; m_busy = 1'b0; m_age = 0; m_tmo = 1'b0; m_perr = 1'b0;
`ifdef ROUND_ROBIN_EN
         m_last = 0;
`endif
      end else begin
         m_eff = req;
         for (int s = 0; s < S; s++) m_eff = m_eff | split_req[s*N +: N];
         m_perr = 1'b0;
         for (int m = 0; m < N; m++) if (util[m] && m != m_own) m_perr = 1'b1;
         m_tmo = 1'b0;
         if (m_own < 0) begin
            if (m_eff != 0) model_grant();
         end else if (m_busy) begin
            if (!util[m_own]) begin
               if (m_eff != 0) model_grant();
               else m_own = -1;
            end
         end else if (util[m_own]) begin
            m_busy = 1'b1;
         end else if (!m_eff[m_own]) begin
            m_own = -1;
         end else begin
            m_age++;
            if (m_age == T) begin
               m_own = -1;
               m_tmo = 1'b1;
            end
         end
      end
   end

   // Compare process: outputs are registered, so the falling edge sees a settled value.
   always @(negedge clk) begin
      check("m_grant",     32'(grant),     32'(own_vec(m_own)));
      check("m_gmaster",   32'(gmaster),   32'({S{own_vec(m_own)}}));
      check("m_owner_id",  32'(owner_id),  (m_own < 0) ? 32'd0 : 32'(m_own));
      check("m_timeout",   32'(timeout),   32'(m_tmo));
      check("m_proto_err", 32'(proto_err), 32'(m_perr));
   end

   int mode;

   initial begin
      reset = 1'b0; req = '0; util = '0; split_req = '0;
      repeat (2) tick();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_gmaster", 32'(gmaster), 32'h0);
      check("rst_owner", 32'(owner_id), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      check("rst_proto_err", 32'(proto_err), 32'h0);
      reset = 1'b1;
      tick();
      check("idle_grant", 32'(grant), 32'h0);

      req = 2'b11;
      tick();
      check("first_grant", 32'(grant), 32'h2);
      check("first_gmaster", 32'(gmaster), 32'h2a);
      check("first_owner", 32'(owner_id), 32'h1);

      util = 2'b10;
      repeat (5) begin
         tick();
         check("busy_hold", 32'(grant), 32'h2);
      end
      util = 2'b00;
      tick();
`ifdef ROUND_ROBIN_EN
      check("handover_grant", 32'(grant), 32'h1);
      check("handover_gmaster", 32'(gmaster), 32'h15);
      check("handover_owner", 32'(owner_id), 32'h0);
`else
      check("handover_grant", 32'(grant), 32'h2);
      check("handover_gmaster", 32'(gmaster), 32'h2a);
      check("handover_owner", 32'(owner_id), 32'h1);
`endif

      req = 2'b00;
      tick();
      check("drop_grant", 32'(grant), 32'h0);
      tick();

      req = 2'b10;
      tick();
      check("tmo_start", 32'(grant), 32'h2);
      repeat (T - 1) begin
         tick();
         check("tmo_wait_grant", 32'(grant), 32'h2);
         check("tmo_wait_pulse", 32'(timeout), 32'h0);
      end
      tick();
      check("tmo_drop_grant", 32'(grant), 32'h0);
      check("tmo_pulse", 32'(timeout), 32'h1);
      tick();
      check("tmo_regrant", 32'(grant), 32'h2);
      check("tmo_pulse_end", 32'(timeout), 32'h0);

      util = 2'b10;
      tick();
      util = 2'b11;
      tick();
      check("perr_pulse", 32'(proto_err), 32'h1);
      check("perr_grant", 32'(grant), 32'h2);
      util = 2'b10;
      tick();
      check("perr_clear", 32'(proto_err), 32'h0);
      check("perr_grant2", 32'(grant), 32'h2);

      #2 reset = 1'b0;
      #1;
      check("async_rst_grant", 32'(grant), 32'h0);
      check("async_rst_gmaster", 32'(gmaster), 32'h0);
      check("async_rst_owner", 32'(owner_id), 32'h0);
      check("async_rst_timeout", 32'(timeout), 32'h0);
      req = '0; util = '0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      check("post_rst_idle", 32'(grant), 32'h0);

      split_req = 6'b000001;
      tick();
      check("split_grant", 32'(grant), 32'h1);
      check("split_owner", 32'(owner_id), 32'h0);
      split_req = '0;
      tick();
      check("split_release", 32'(grant), 32'h0);

      mode = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 64 == 0) mode = int'($urandom_range(0, 2));
         reset     = ($urandom % 300) != 0;
         split_req = (($urandom % 8) == 0) ? (S*N)'($urandom) : '0;
         case (mode)
            0: begin
               req  = '1;
               util = '0;
            end
            1: begin
               req  = N'($urandom);
               util = (m_own >= 0 && ($urandom % 5) != 0) ? own_vec(m_own) : '0;
            end
            default: begin
               req  = N'($urandom);
               util = N'($urandom);
            end
         endcase
         tick();
      end
      reset = 1'b1; req = '0; util = '0; split_req = '0;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
